// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit owning HI/LO for the multicycle MIPS core.
// Signed ops run on magnitudes; signs are reapplied in the FIX state.
module mdu_seq #(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W  = WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [2*W-1:0] acc_q;
  logic [W-1:0]   dv_q;
  logic [W-1:0]   hi_q, lo_q;
  logic           busy_q, done_q;
  logic           div_q, dz_q, neg_q, rneg_q;

  logic           sgn_in;
  logic [W-1:0]   ma, mb;
  logic [2*W-1:0] fprod;
  logic [W:0]     msum;
  logic [2*W-1:0] mul_step;
  logic [W:0]     rsh, rdiff;
  logic           ge;
  logic [W-1:0]   rnew;
  logic [2*W-1:0] div_step;
  logic [2*W-1:0] prod_f;
  logic [W-1:0]   q_f, r_f;

  always_comb begin
    sgn_in = ~op[0];
    ma     = (sgn_in && a[W-1]) ? -a : a;
    mb     = (sgn_in && b[W-1]) ? -b : b;
    fprod  = {{W{1'b0}}, ma} * {{W{1'b0}}, mb};
  end

  // Multiply: acc = {partial, multiplier}, shift right one bit per step.
  always_comb begin
    msum     = {1'b0, acc_q[2*W-1:W]}
             + (acc_q[0] ? {1'b0, dv_q} : {(W+1){1'b0}});
    mul_step = {msum, acc_q[W-1:1]};
  end

  // Divide: acc = {remainder, dividend/quotient}, restoring step.
  always_comb begin
    rsh      = {acc_q[2*W-1:W], acc_q[W-1]};
    ge       = (rsh >= {1'b0, dv_q});
    rdiff    = rsh - {1'b0, dv_q};
    rnew     = ge ? rdiff[W-1:0] : rsh[W-1:0];
    div_step = {rnew, acc_q[W-2:0], ge};
  end

  always_comb begin
    prod_f = neg_q ? -acc_q : acc_q;
    q_f    = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    r_f    = rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dv_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (mthi) hi_q <= wdata;
          if (mtlo) lo_q <= wdata;
          if (start) begin
            busy_q <= 1'b1;
            div_q  <= op[1];
            cnt_q  <= '0;
            dz_q   <= 1'b0;
            neg_q  <= sgn_in & (a[W-1] ^ b[W-1]);
            rneg_q <= sgn_in & a[W-1];
            dv_q   <= mb;
            if (op[1] && b == '0) begin
              dz_q    <= 1'b1;
              acc_q   <= {a, {W{1'b1}}};
              state_q <= FIX;
            end else if (op[1]) begin
              acc_q   <= {{W{1'b0}}, ma};
              state_q <= CALC;
            end else if (FAST_MUL) begin
              acc_q   <= fprod;
              state_q <= FIX;
            end else begin
              acc_q   <= {{W{1'b0}}, mb};
              dv_q    <= ma;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          acc_q <= div_q ? div_step : mul_step;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(W-1)) state_q <= FIX;
        end
        FIX: begin
          if (dz_q) begin
            hi_q <= acc_q[2*W-1:W];
            lo_q <= acc_q[W-1:0];
          end else if (div_q) begin
            hi_q <= r_f;
            lo_q <= q_f;
          end else begin
            hi_q <= prod_f[2*W-1:W];
            lo_q <= prod_f[W-1:0];
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
